// File: rtl/in_debounce_pkg.sv
// Shared types and constants for the switch/button debouncer.
// Holds the per-channel FSM state encoding and the default channel count.
package in_debounce_pkg;

    localparam int unsigned N_IN_DEFAULT = 5;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_e;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser chain, stability counter and FSM.
// Outputs a registered level plus one-cycle rise/fall pulses on acceptance.
module debounce_chan
    import in_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 3_000_000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    db_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   db_d, rise_d, fall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                cnt_d = '0;
                if (sync) begin
                    state_d = WAIT_HI;
                    cnt_d   = ONE;
                end
            end
            WAIT_HI: begin
                if (!sync) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CMAX) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    db_d    = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            STABLE_HI: begin
                cnt_d = '0;
                if (!sync) begin
                    state_d = WAIT_LO;
                    cnt_d   = ONE;
                end
            end
            WAIT_LO: begin
                if (sync) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CMAX) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    db_d    = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
                db_d    = 1'b0;
            end
        endcase
    end

    // Level and pulses are registered together so they line up exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            db      <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db      <= db_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

endmodule

// File: rtl/in_debounce.sv
// Multi-channel debouncer for raw board switch/button levels.
// Each channel is an independent debounce_chan instance.
module in_debounce
    import in_debounce_pkg::*;
#(
    parameter int unsigned N_IN            = N_IN_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = 3_000_000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic            clk_300,
    input  logic            rst_n,
    input  logic [N_IN-1:0] in,
    output logic [N_IN-1:0] in_db,
    output logic [N_IN-1:0] rise,
    output logic [N_IN-1:0] fall
);

    for (genvar i = 0; i < N_IN; i++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_chan (
            .clk   (clk_300),
            .rst_n (rst_n),
            .raw   (in[i]),
            .db    (in_db[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_in_debounce.sv
// Scoreboard bench for in_debounce with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Expected pulses are queued with their due cycle when stimulus is driven.
`timescale 1ns/1ps
module tb_in_debounce;

    localparam int N   = 5;
    localparam int LAT = 6;

    typedef struct {
        int   at;
        int   ch;
        logic dir;
    } ev_t;

    logic         clk_300;
    logic         rst_n;
    logic [N-1:0] in;
    logic [N-1:0] in_db;
    logic [N-1:0] rise;
    logic [N-1:0] fall;

    int           total;
    int           bad;
    int           cyc;
    ev_t          sb[$];
    ev_t          ev;
    logic [N-1:0] prev_db;

    in_debounce #(
        .N_IN            (N),
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .clk_300 (clk_300),
        .rst_n   (rst_n),
        .in      (in),
        .in_db   (in_db),
        .rise    (rise),
        .fall    (fall)
    );

    initial clk_300 = 1'b0;
    always #1.667 clk_300 = ~clk_300;

    always @(posedge clk_300) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_300);
    endtask

    // Called at a negedge right where the new level is driven.
    task automatic expect_ev(input int ch, input logic dir);
        ev_t e;
        e.at  = cyc + 1 + LAT;
        e.ch  = ch;
        e.dir = dir;
        sb.push_back(e);
    endtask

    always @(negedge clk_300) begin
        if (!rst_n) begin
            prev_db = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (rise[i] && fall[i])
                    check("rise_fall_excl", 1, 0);
                if (rise[i] || fall[i]) begin
                    if (sb.size() == 0) begin
                        check("unexpected_pulse", i, -1);
                    end else begin
                        ev = sb.pop_front();
                        check("pulse_cyc", cyc, ev.at);
                        check("pulse_ch", i, ev.ch);
                        check("pulse_dir", int'(rise[i]), int'(ev.dir));
                        check("db_level", int'(in_db[i]), int'(ev.dir));
                    end
                end else if (in_db[i] != prev_db[i]) begin
                    check("db_nopulse", int'(in_db[i]), int'(prev_db[i]));
                end
            end
            prev_db = in_db;
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst_n = 1'b0;
        in    = 5'b11111;

        // Reset holds everything low even with all inputs high
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("rst_db", int'(in_db), 0);
            check("rst_rise", int'(rise), 0);
            check("rst_fall", int'(fall), 0);
        end
        in = '0;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        check("idle_db", int'(in_db), 0);

        // Clean rise on ch0, then clean fall
        in[0] = 1'b1;
        expect_ev(0, 1'b1);
        tick(12);
        check("clean_rise_db", int'(in_db), 5'b00001);
        in[0] = 1'b0;
        expect_ev(0, 1'b0);
        tick(12);
        check("clean_fall_db", int'(in_db), 0);

        // Glitch on ch1 shorter than the debounce window
        in[1] = 1'b1;
        tick(3);
        in[1] = 1'b0;
        tick(12);
        check("glitch_db", int'(in_db), 0);

        // Bounce to 1 on ch2
        for (int k = 0; k < 5; k++) begin
            in[2] = (k % 2 == 0);
            if (k == 4) expect_ev(2, 1'b1);
            tick(2);
        end
        tick(10);
        check("bounce_hi_db", int'(in_db), 5'b00100);

        // Bounce back to 0 on ch2
        for (int k = 0; k < 5; k++) begin
            in[2] = (k % 2 != 0);
            if (k == 4) expect_ev(2, 1'b0);
            tick(2);
        end
        tick(10);
        check("bounce_lo_db", int'(in_db), 0);
        check("sb_empty_a", sb.size(), 0);

        // Reset mid-count: no pulse, full latency after release
        in[0] = 1'b1;
        tick(5);
        rst_n = 1'b0;
        tick(1);
        check("midrst_db", int'(in_db), 0);
        tick(2);
        check("midrst_rise", int'(rise), 0);
        rst_n = 1'b1;
        expect_ev(0, 1'b1);
        tick(LAT);
        check("midrst_early", int'(in_db[0]), 0);
        tick(6);
        check("midrst_db_hi", int'(in_db), 5'b00001);

        // Simultaneous rises on ch3 and ch4
        in[3] = 1'b1;
        in[4] = 1'b1;
        expect_ev(3, 1'b1);
        expect_ev(4, 1'b1);
        tick(12);
        check("simul_db", int'(in_db), 5'b11001);
        check("sb_empty_b", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
